// File: rtl/key_entry_pkg.sv
// Shared key codes, FSM state type and a constant helper for the key_entry block.
package key_entry_pkg;

   localparam logic [3:0] KEY_ENTER = 4'hA;
   localparam logic [3:0] KEY_BKSP  = 4'hB;
   localparam logic [3:0] KEY_CLR   = 4'hC;

   typedef enum logic [1:0] {
      StEntry,
      StConvert,
      StSubmit
   } state_e;

   function automatic longint unsigned pow10(input int unsigned n);
      longint unsigned p;
      p = 1;
      for (int unsigned i = 0; i < n; i++) begin
         p = p * 10;
      end
      return p;
   endfunction

endpackage

// File: rtl/key_qualifier.sv
// Turns the scanner's level-style key_valid/key_code into one registered key_evt per press,
// re-arming only after the key has been released for DEBOUNCE_CYC cycles.
module key_qualifier
   import key_entry_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic       key_evt,
   output logic [3:0] evt_code
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);

   logic          r_armed;
   logic [CW-1:0] r_cnt;
   logic [3:0]    r_code;
   logic          r_evt;
   logic [3:0]    r_evt_code;
   logic [CW-1:0] w_cnt_next;

   // One counter serves both phases: held cycles while armed, released cycles while disarmed.
   always_comb begin
      w_cnt_next = '0;
      if (r_armed) begin
         if (key_valid) begin
            if ((r_cnt != '0) && (key_code == r_code)) begin
               w_cnt_next = r_cnt + CW'(1);
            end else begin
               w_cnt_next = CW'(1);
            end
         end
      end else if (!key_valid) begin
         w_cnt_next = r_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_armed    <= 1'b1;
         r_cnt      <= '0;
         r_code     <= '0;
         r_evt      <= 1'b0;
         r_evt_code <= '0;
      end else begin
         r_evt  <= 1'b0;
         r_code <= key_code;
         if (r_armed && (w_cnt_next == CW'(DEBOUNCE_CYC))) begin
            r_evt      <= 1'b1;
            r_evt_code <= key_code;
            r_armed    <= 1'b0;
            r_cnt      <= '0;
         end else if (!r_armed && (w_cnt_next == CW'(DEBOUNCE_CYC))) begin
            r_armed <= 1'b1;
            r_cnt   <= '0;
         end else begin
            r_cnt <= w_cnt_next;
         end
      end
   end

   assign key_evt  = r_evt;
   assign evt_code = r_evt_code;

endmodule

// File: rtl/key_entry.sv
// Multi-digit decimal key entry with serial BCD-to-binary conversion and valid/ready output.
// Optional KEY_ENTRY_AUTO_SUBMIT_EN: a full entry starts conversion without Enter.
module key_entry
   import key_entry_pkg::*;
#(
   parameter int unsigned MAX_DIGITS   = 4,
   parameter int unsigned VALUE_W      = 14,
   parameter int unsigned DEBOUNCE_CYC = 3
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             key_valid,
   input  logic [3:0]                       key_code,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [VALUE_W-1:0]               out_value,
   output logic [$clog2(MAX_DIGITS+1)-1:0]  out_ndigits,
   output logic [4*MAX_DIGITS-1:0]          disp_bcd,
   output logic [$clog2(MAX_DIGITS+1)-1:0]  disp_ndigits,
   output logic                             busy,
   output logic                             overflow
);

   localparam int unsigned ND_W  = $clog2(MAX_DIGITS + 1);
   localparam int unsigned IDX_W = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;

   if (pow10(MAX_DIGITS) - 64'd1 > (64'd1 << VALUE_W) - 64'd1) begin : g_value_w_check
      $error("key_entry: VALUE_W too narrow to hold MAX_DIGITS decimal digits");
   end

   state_e                  r_state, w_state_next;
   logic [4*MAX_DIGITS-1:0] r_bcd, w_bcd_next;
   logic [ND_W-1:0]         r_ndig, w_ndig_next;
   logic [VALUE_W-1:0]      r_acc, w_acc_next;
   logic [IDX_W-1:0]        r_idx, w_idx_next;
   logic [VALUE_W-1:0]      r_out_value, w_out_value_next;
   logic [ND_W-1:0]         r_out_nd, w_out_nd_next;
   logic                    r_ovf, w_ovf_next;

   logic                    w_key_evt;
   logic [3:0]              w_evt_code;
   logic [3:0]              w_digit;
   logic [VALUE_W-1:0]      w_acc_mac;

   key_qualifier #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_qual (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_evt   (w_key_evt),
      .evt_code  (w_evt_code)
   );

   assign w_digit   = r_bcd[{r_idx, 2'b00} +: 4];
   // acc*10 + digit as (acc<<3)+(acc<<1) with 4 guard bits; the parameter check makes truncation exact.
   assign w_acc_mac = VALUE_W'(({4'b0000, r_acc} << 3) + ({4'b0000, r_acc} << 1)
                               + {{VALUE_W{1'b0}}, w_digit});

   always_comb begin
      w_state_next     = r_state;
      w_bcd_next       = r_bcd;
      w_ndig_next      = r_ndig;
      w_acc_next       = r_acc;
      w_idx_next       = r_idx;
      w_out_value_next = r_out_value;
      w_out_nd_next    = r_out_nd;
      w_ovf_next       = 1'b0;

      case (r_state)
         StEntry: begin
`ifdef KEY_ENTRY_AUTO_SUBMIT_EN
            if (r_ndig == ND_W'(MAX_DIGITS)) begin
               w_acc_next   = '0;
               w_idx_next   = IDX_W'(MAX_DIGITS - 1);
               w_state_next = StConvert;
            end else
`endif
            if (w_key_evt) begin
               if (w_evt_code <= 4'd9) begin
                  if (r_ndig < ND_W'(MAX_DIGITS)) begin
                     w_bcd_next      = r_bcd << 4;
                     w_bcd_next[3:0] = w_evt_code;
                     w_ndig_next     = r_ndig + ND_W'(1);
                  end else begin
                     w_ovf_next = 1'b1;
                  end
               end else if (w_evt_code == KEY_BKSP) begin
                  if (r_ndig != '0) begin
                     w_bcd_next  = r_bcd >> 4;
                     w_ndig_next = r_ndig - ND_W'(1);
                  end
               end else if (w_evt_code == KEY_CLR) begin
                  w_bcd_next  = '0;
                  w_ndig_next = '0;
               end else if (w_evt_code == KEY_ENTER) begin
                  if (r_ndig != '0) begin
                     w_acc_next   = '0;
                     w_idx_next   = IDX_W'(r_ndig - ND_W'(1));
                     w_state_next = StConvert;
                  end
               end
            end
         end

         StConvert: begin
            w_acc_next = w_acc_mac;
            if (r_idx == '0) begin
               w_out_value_next = w_acc_mac;
               w_out_nd_next    = r_ndig;
               w_state_next     = StSubmit;
            end else begin
               w_idx_next = r_idx - IDX_W'(1);
            end
         end

         StSubmit: begin
            if (out_ready) begin
               w_bcd_next   = '0;
               w_ndig_next  = '0;
               w_state_next = StEntry;
            end
         end

         default: w_state_next = StEntry;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= StEntry;
         r_bcd       <= '0;
         r_ndig      <= '0;
         r_acc       <= '0;
         r_idx       <= '0;
         r_out_value <= '0;
         r_out_nd    <= '0;
         r_ovf       <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_bcd       <= w_bcd_next;
         r_ndig      <= w_ndig_next;
         r_acc       <= w_acc_next;
         r_idx       <= w_idx_next;
         r_out_value <= w_out_value_next;
         r_out_nd    <= w_out_nd_next;
         r_ovf       <= w_ovf_next;
      end
   end

   assign out_valid    = (r_state == StSubmit);
   assign busy         = (r_state != StEntry);
   assign out_value    = r_out_value;
   assign out_ndigits  = r_out_nd;
   assign disp_bcd     = r_bcd;
   assign disp_ndigits = r_ndig;
   assign overflow     = r_ovf;

endmodule
